// File: rtl/datastream_tx_arbiter_if.sv
// Stream request and UART byte handshake bundle for the datastream TX arbiter.
// master = arbiter side, slave = stream producers plus UART transmitter.
interface datastream_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ack;
  logic        uart_start;
  logic [7:0]  uart_data;
  logic        uart_done;

  modport master (
    input  req_valid, req_data, uart_done,
    output req_ack, uart_start, uart_data
  );

  modport slave (
    output req_valid, req_data, uart_done,
    input  req_ack, uart_start, uart_data
  );
endinterface

// File: rtl/datastream_tx_arbiter.sv
// Round-robin arbiter serialising 16-bit stream words into UART bytes, with an idle rest gap after each byte.
// Optional macro STREAM_TAG_EN prefixes each word with an ASCII stream-id tag byte ('0'..'3').
module datastream_tx_arbiter #(
  parameter int unsigned              TIMER_WIDTH = 10,
  parameter logic [TIMER_WIDTH-1:0]   REST_CYCLES = 10'd385
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           bt_state,
  datastream_tx_arbiter_if.master        bus,
  output logic                           busy,
  output logic [1:0]                     grant_id,
  output logic [3:0]                     curr_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'h0,
    S_CAPTURE   = 4'h1,
    S_LOAD_BYTE = 4'h2,
    S_SEND      = 4'h3,
    S_REST      = 4'h4
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] REST_LAST = REST_CYCLES - 1'b1;
`ifdef STREAM_TAG_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  state_t                 r_state;
  logic [15:0]            r_word;
  logic [1:0]             r_last_grant;
  logic [1:0]             r_byte_idx;
  logic [TIMER_WIDTH-1:0] r_timer;

  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_cand;
  logic [7:0] w_byte;

  // Search begins one past the last winner, so the last winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last_grant;
    w_cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last_grant + 2'(k);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

`ifdef STREAM_TAG_EN
  always_comb begin
    case (r_byte_idx)
      2'd0:    w_byte = 8'h30 + {6'd0, grant_id};
      2'd1:    w_byte = r_word[15:8];
      default: w_byte = r_word[7:0];
    endcase
  end
`else
  always_comb begin
    w_byte = (r_byte_idx == 2'd0) ? r_word[15:8] : r_word[7:0];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_word         <= '0;
      r_last_grant   <= 2'd3;
      r_byte_idx     <= '0;
      r_timer        <= '0;
      bus.req_ack    <= '0;
      bus.uart_start <= 1'b0;
      bus.uart_data  <= 8'h00;
      busy           <= 1'b0;
      grant_id       <= 2'd0;
    end else begin
      bus.req_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (enable && bt_state && w_found) begin
            r_state      <= S_CAPTURE;
            r_word       <= bus.req_data[{w_win, 4'b0000} +: 16];
            grant_id     <= w_win;
            r_last_grant <= w_win;
            bus.req_ack  <= 4'b0001 << w_win;
            busy         <= 1'b1;
          end
        end
        S_CAPTURE: begin
          r_byte_idx <= '0;
          r_state    <= S_LOAD_BYTE;
        end
        S_LOAD_BYTE: begin
          bus.uart_data  <= w_byte;
          bus.uart_start <= 1'b1;
          r_state        <= S_SEND;
        end
        S_SEND: begin
          if (bus.uart_done) begin
            bus.uart_start <= 1'b0;
            r_timer        <= '0;
            r_state        <= S_REST;
          end
        end
        S_REST: begin
          // Enable/bt_state are not consulted here: an acked word always completes.
          if (r_timer == REST_LAST) begin
            if (r_byte_idx != LAST_BYTE) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= S_LOAD_BYTE;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          bus.uart_start <= 1'b0;
          busy           <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign curr_state = r_state;

endmodule

// File: tb/tb_datastream_tx_arbiter.sv
// Directed bench for datastream_tx_arbiter with REST_CYCLES=4 and a UART model returning done 3 cycles after start.
module tb_datastream_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       bt_state = 1'b1;
  logic       busy;
  logic [1:0] grant_id;
  logic [3:0] curr_state;

  logic done_resp = 1'b0;
  logic done_spur = 1'b0;
  logic rest_skip = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  logic [3:0] ack_q[$];
  logic [1:0] gid_q[$];

  datastream_tx_arbiter_if bus();

  assign bus.uart_done = done_resp | done_spur;

  datastream_tx_arbiter #(
    .TIMER_WIDTH (10),
    .REST_CYCLES (10'd4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .bt_state   (bt_state),
    .bus        (bus),
    .busy       (busy),
    .grant_id   (grant_id),
    .curr_state (curr_state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [1:0] id, input logic [15:0] w);
`ifdef STREAM_TAG_EN
    exp_q.push_back(8'h30 + {6'd0, id});
`endif
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endfunction

  task automatic compare_bytes(input string tag);
    int n;
    check_eq({tag, "_nbytes"}, byte_q.size(), exp_q.size());
    n = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, byte_q[i], exp_q[i]);
    byte_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (curr_state != s && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, curr_state, s);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!bus.uart_start && n < 300) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, bus.uart_start, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  // UART model: done pulse lands three cycles after start rises.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.uart_start && !prev) begin
        repeat (2) @(negedge clock);
        done_resp = 1'b1;
        @(negedge clock);
        done_resp = 1'b0;
        prev = bus.uart_start;
      end else begin
        prev = bus.uart_start;
      end
    end
  end

  // Byte capture, data-hold, ack log and rest-length monitors.
  initial begin
    logic       prev = 1'b0;
    logic [7:0] held = 8'h00;
    int         rest_cnt = 0;
    forever begin
      @(negedge clock);
      if (bus.uart_start && !prev) begin
        byte_q.push_back(bus.uart_data);
        held = bus.uart_data;
      end else if (bus.uart_start && prev) begin
        check_eq("data_hold", bus.uart_data, held);
      end
      prev = bus.uart_start;
      if (bus.req_ack != 4'b0000) begin
        ack_q.push_back(bus.req_ack);
        gid_q.push_back(grant_id);
      end
      if (curr_state == 4'h4) begin
        rest_cnt++;
      end else if (rest_cnt != 0) begin
        if (!rest_skip) check_eq("rest_len", rest_cnt, 4);
        rest_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 4'b0000;
    bus.req_data  = {16'h3B29, 16'h6E49, 16'h5B5D, 16'h4869};

    // Reset values
    do_reset();
    check_eq("rst_state", curr_state, 4'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_start", bus.uart_start, 1'b0);
    check_eq("rst_data", bus.uart_data, 8'h00);
    check_eq("rst_gid", grant_id, 2'd0);
    check_eq("rst_ack", bus.req_ack, 4'b0000);

    // Single stream, latency and byte order
    bus.req_valid = 4'b0001;
    @(negedge clock);
    check_eq("lat_ack", bus.req_ack, 4'b0001);
    check_eq("lat_state_cap", curr_state, 4'h1);
    check_eq("lat_busy", busy, 1'b1);
    bus.req_valid = 4'b0000;
    @(negedge clock);
    check_eq("ack_pulse_end", bus.req_ack, 4'b0000);
    check_eq("lat_state_load", curr_state, 4'h2);
    @(negedge clock);
    check_eq("lat_start", bus.uart_start, 1'b1);
    check_eq("lat_state_send", curr_state, 4'h3);
`ifdef STREAM_TAG_EN
    check_eq("lat_first_byte", bus.uart_data, 8'h30);
`else
    check_eq("lat_first_byte", bus.uart_data, 8'h48);
`endif
    wait_state(4'h0, "single_idle");
    push_word(2'd0, 16'h4869);
    compare_bytes("single");
    check_eq("single_nack", ack_q.size(), 1);
    ack_q.delete();
    gid_q.delete();

    // Round robin across all four streams
    do_reset();
    bus.req_valid = 4'b1111;
    begin
      int n = 0;
      while (ack_q.size() < 5 && n < 2000) begin
        @(negedge clock);
        n++;
      end
    end
    bus.req_valid = 4'b0000;
    check_eq("rr_nack", ack_q.size(), 5);
    wait_state(4'h0, "rr_idle");
    begin
      logic [1:0]  exp_gid[5];
      logic [15:0] w[4];
      exp_gid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      w = '{16'h4869, 16'h5B5D, 16'h6E49, 16'h3B29};
      for (int i = 0; i < 5 && i < ack_q.size(); i++) begin
        check_eq("rr_gid", gid_q[i], exp_gid[i]);
        check_eq("rr_ack", ack_q[i], 4'b0001 << exp_gid[i]);
        push_word(exp_gid[i], w[exp_gid[i]]);
      end
    end
    compare_bytes("rr");
    ack_q.delete();
    gid_q.delete();

    // Disconnect mid-word
    bus.req_valid = 4'b0010;
    wait_start("disc_start");
    bt_state = 1'b0;
    wait_state(4'h0, "disc_idle");
    repeat (10) @(negedge clock);
    check_eq("disc_nack", ack_q.size(), 1);
    check_eq("disc_hold_state", curr_state, 4'h0);
    bt_state = 1'b1;
    @(negedge clock);
    check_eq("reconn_ack", bus.req_ack, 4'b0010);
    bus.req_valid = 4'b0000;
    wait_state(4'h0, "reconn_idle");
    push_word(2'd1, 16'h5B5D);
    push_word(2'd1, 16'h5B5D);
    compare_bytes("disc");
    ack_q.delete();
    gid_q.delete();

    // Reset during REST cycle 2
    bus.req_valid = 4'b0100;
    wait_state(4'h4, "rrst_rest");
    bus.req_valid = 4'b0000;
    @(negedge clock);
    rest_skip = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check_eq("rrst_state", curr_state, 4'h0);
    check_eq("rrst_start", bus.uart_start, 1'b0);
    check_eq("rrst_busy", busy, 1'b0);
    check_eq("rrst_gid", grant_id, 2'd0);
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clock);
    check_eq("rrst_next_ack", bus.req_ack, 4'b0001);
    check_eq("rrst_next_gid", grant_id, 2'd0);
    bus.req_valid = 4'b0000;
    wait_state(4'h0, "rrst_idle");
    rest_skip = 1'b0;
`ifdef STREAM_TAG_EN
    exp_q.push_back(8'h32);
`else
    exp_q.push_back(8'h6E);
`endif
    push_word(2'd0, 16'h4869);
    compare_bytes("rrst");
    ack_q.delete();
    gid_q.delete();

    // Spurious uart_done in IDLE and in REST
    done_spur = 1'b1;
    @(negedge clock);
    done_spur = 1'b0;
    check_eq("spur_idle_state", curr_state, 4'h0);
    check_eq("spur_idle_busy", busy, 1'b0);
    bus.req_valid = 4'b1000;
    wait_state(4'h4, "spur_rest");
    bus.req_valid = 4'b0000;
    done_spur = 1'b1;
    @(negedge clock);
    done_spur = 1'b0;
    check_eq("spur_rest_state", curr_state, 4'h4);
    wait_state(4'h0, "spur_idle_end");
    check_eq("spur_gid", grant_id, 2'd3);
    push_word(2'd3, 16'h3B29);
    compare_bytes("spur");

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/datastream_tx_arbiter.md
DATASTREAM_TX_ARBITER -- requirements
Module: datastream_tx_arbiter

Interface
REQ-001 Parameter REST_CYCLES, default 10'd385: clock cycles of idle line enforced after each transmitted byte.
REQ-002 Parameter TIMER_WIDTH, default 10: width of the rest timer; REST_CYCLES SHALL fit in it.
REQ-003 clock  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  permits new word grants.
REQ-006 bt_state  in  1  HC-05 connected indication; 1 = connected.
REQ-007 req_valid  in  4  stream i has a 16-bit word pending.
REQ-008 req_data  in  64  stream i word on bits [16i+15:16i].
REQ-009 req_ack  out  4  one-cycle pulse on bit i when stream i's word is captured.
REQ-010 uart_start  out  1  level start to UART_tx.
REQ-011 uart_data  out  8  byte to UART_tx.
REQ-012 uart_done  in  1  UART_tx completion pulse.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 grant_id  out  2  id of the stream currently or last served.
REQ-015 curr_state  out  4  FSM state encoding, for wireOut debug.

Function
REQ-016 The FSM SHALL have these states and encodings: IDLE 4'h0, CAPTURE 4'h1, LOAD_BYTE 4'h2, SEND 4'h3, REST 4'h4.
REQ-017 IDLE SHALL go to CAPTURE when enable & bt_state & |req_valid; otherwise it SHALL remain in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4 and wraps 3->0; the first valid stream wins.
REQ-019 In CAPTURE the block SHALL latch the winner's word and id, update last_grant, pulse req_ack[id] for exactly that cycle, and go to LOAD_BYTE.
REQ-020 The byte order SHALL be MSB byte first, then LSB byte.
REQ-021 LOAD_BYTE SHALL drive uart_data from byte_index and go to SEND after one cycle.
REQ-022 In SEND, uart_start SHALL be 1 and uart_data SHALL be held stable.
REQ-023 SEND SHALL go to REST on uart_done; uart_done in any other state SHALL be ignored.
REQ-024 On entering REST the timer SHALL clear to 0, then increment each cycle.
REQ-025 REST SHALL exit when the timer equals REST_CYCLES-1, giving exactly REST_CYCLES cycles in REST.
REQ-026 On REST exit, if bytes remain, byte_index SHALL increment and the FSM SHALL go to LOAD_BYTE; otherwise it SHALL go to IDLE.
REQ-027 Once acked, a word SHALL be sent completely: loss of bt_state or enable mid-word SHALL only block the next grant.
REQ-028 A req_valid change after CAPTURE SHALL NOT affect the word in flight.
REQ-029 Latency: req_valid rising in IDLE with enable=bt_state=1 SHALL give req_ack on the next cycle and uart_start two cycles after that.
REQ-030 Outside SEND, uart_start SHALL be 0.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set state=IDLE, req_ack=0, uart_start=0, uart_data=8'h00, busy=0, grant_id=2'd0, timer=0, byte_index=0, and last_grant=2'd3 (stream 0 wins first).
REQ-032 Reset asserted mid-SEND or mid-REST SHALL abort the word without any ack or retry.

Configuration
REQ-033 Macro STREAM_TAG_EN defined: each word SHALL be preceded by a tag byte 8'h30+id (ASCII '0'..'3'), giving 3 bytes per word in the order tag, MSB, LSB.
REQ-034 STREAM_TAG_EN undefined: each word SHALL be 2 bytes, MSB then LSB, and no tag logic SHALL be present.

Verification (REST_CYCLES=4, uart_done returned 3 cycles after uart_start rises)
REQ-035 Single stream: req_valid=4'b0001, word 16'h4869 -> req_ack=4'b0001 one cycle; uart_data 8'h48 then 8'h69; each byte followed by 4 REST cycles; then IDLE.
REQ-036 Round-robin: all four streams valid with words 16'h4869, 16'h5B5D, 16'h6E49, 16'h3B29 -> grant_id sequence 0,1,2,3,0 with one ack per grant.
REQ-037 Disconnect: bt_state falls during the SEND of the MSB byte -> the LSB byte is still sent; no new ack until bt_state=1.
REQ-038 Reset at REST cycle 2 -> next cycle state=IDLE, uart_start=0, busy=0; the next grant goes to stream 0.
REQ-039 STREAM_TAG_EN defined, stream 2 word 16'h6E49 -> bytes 8'h32, 8'h6E, 8'h49.
REQ-040 Spurious uart_done pulse in IDLE or REST -> no state change, and exactly REST_CYCLES cycles still spent in REST.
